// File: rtl/axi_stream_pckg.sv
// Shared AXI-Stream unload parameters and the unload controller state type.
package axi_stream_pckg;

   localparam int VLW_WDT           = 64;
   localparam int M_TDATA_WDT       = 32;
   localparam int C_FFT_SIZE_LOG2   = 12;
   localparam int M_FIFO_SIZE       = 16;
   localparam int M_IF_BUFFER_SIZE  = VLW_WDT / M_TDATA_WDT;
   localparam int M_PACKET_CNT      = (1 << C_FFT_SIZE_LOG2) * M_IF_BUFFER_SIZE;
   localparam int OUTPUT_MEM_OFFSET = 0;
   localparam int MEM_RD_LAT        = 1;

   typedef enum logic [1:0] {
      UNLD_IDLE,
      UNLD_READ,
      UNLD_DRAIN
   } unload_state_t;

   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/axis_m_fft_unload_ctrl_fifo.sv
// First-word-fall-through word FIFO; zero-latency read of the head, one-cycle write.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module axis_word_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_dat_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           pop_dat_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign count_o   = count_q;
   assign pop_dat_o = mem_q[rd_ptr_q];
   assign do_pop    = pop_i && !empty_o;
   assign do_push   = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

endmodule

// File: rtl/axis_m_fft_unload_ctrl.sv
// Streams one FFT frame from result memory to AXI-Stream, upper slice first; first beat 2+MEM_RD_LAT
// cycles after start, then 1 beat/cycle. tready low stalls reads once FD words are buffered or in flight.
module axis_m_fft_unload_ctrl
   import axi_stream_pckg::*;
#(
   parameter int VLW_WDT           = axi_stream_pckg::VLW_WDT,
   parameter int M_TDATA_WDT       = axi_stream_pckg::M_TDATA_WDT,
   parameter int C_FFT_SIZE_LOG2   = axi_stream_pckg::C_FFT_SIZE_LOG2,
   parameter int M_FIFO_SIZE       = axi_stream_pckg::M_FIFO_SIZE,
   parameter int OUTPUT_MEM_OFFSET = axi_stream_pckg::OUTPUT_MEM_OFFSET,
   parameter int MEM_RD_LAT        = axi_stream_pckg::MEM_RD_LAT
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       mem_rd_en_o,
   output logic [C_FFT_SIZE_LOG2-1:0] mem_rd_addr_o,
   input  logic [VLW_WDT-1:0]         mem_rd_data_i,
   output logic [M_TDATA_WDT-1:0]     m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast
);
   localparam int N        = 1 << C_FFT_SIZE_LOG2;
   localparam int SLICES   = VLW_WDT / M_TDATA_WDT;
   localparam int PKT_CNT  = N * SLICES;
   localparam int FD       = M_FIFO_SIZE / SLICES;
   localparam int BEAT_W   = clog2_min1(PKT_CNT);
   localparam int SLICE_W  = clog2_min1(SLICES);
   localparam int CNT_W    = $clog2(FD + 1);
   localparam int INF_W    = $clog2(MEM_RD_LAT + 1);
   localparam int OCC_W    = CNT_W + INF_W;
   localparam logic [C_FFT_SIZE_LOG2-1:0] ADDR_OFS = C_FFT_SIZE_LOG2'(OUTPUT_MEM_OFFSET % N);

   unload_state_t              state_q, state_d;
   logic [C_FFT_SIZE_LOG2-1:0] rd_cnt_q, rd_cnt_d;
   logic [MEM_RD_LAT-1:0]      rd_pipe_q, rd_pipe_d;
   logic [SLICE_W-1:0]         slice_q, slice_d;
   logic [BEAT_W-1:0]          beat_q, beat_d;
   logic                       done_q, done_d;

   logic [INF_W-1:0]   inflight;
   logic [OCC_W-1:0]   occupancy;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full, fifo_empty;
   logic [VLW_WDT-1:0] fifo_dat;
   logic               rd_issue, hs, last_slice, last_beat, fifo_pop;

   // rd_pipe_q[i] marks a read issued i+1 cycles ago; the oldest entry is the returning word.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_RD_LAT; i++) begin
         inflight = inflight + INF_W'(rd_pipe_q[i]);
      end
   end

   assign occupancy     = OCC_W'(fifo_count) + OCC_W'(inflight);
   assign rd_issue      = (state_q == UNLD_READ) && (occupancy < OCC_W'(FD));
   assign mem_rd_en_o   = rd_issue;
   assign mem_rd_addr_o = rd_issue ? (ADDR_OFS + rd_cnt_q) : '0;

   assign m_axis_tvalid = !fifo_empty;
   assign hs            = m_axis_tvalid && m_axis_tready;
   assign last_slice    = (slice_q == SLICE_W'(SLICES - 1));
   assign last_beat     = (beat_q == BEAT_W'(PKT_CNT - 1));
   assign fifo_pop      = hs && last_slice;
   assign m_axis_tlast  = m_axis_tvalid && last_beat;
   assign m_axis_tdata  = m_axis_tvalid
                        ? M_TDATA_WDT'(fifo_dat >> (M_TDATA_WDT * (SLICES - 1 - int'(slice_q))))
                        : '0;

   assign busy_o = (state_q != UNLD_IDLE);
   assign done_o = done_q;

   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = rd_cnt_q;
      slice_d   = slice_q;
      beat_d    = beat_q;
      done_d    = 1'b0;
      rd_pipe_d = MEM_RD_LAT'({rd_pipe_q, rd_issue});

      if (hs) begin
         slice_d = last_slice ? '0 : slice_q + SLICE_W'(1);
         beat_d  = beat_q + BEAT_W'(1);
      end

      case (state_q)
         UNLD_IDLE: begin
            if (start_i) begin
               state_d  = UNLD_READ;
               rd_cnt_d = '0;
               slice_d  = '0;
               beat_d   = '0;
            end
         end
         UNLD_READ: begin
            if (rd_issue) begin
               rd_cnt_d = rd_cnt_q + C_FFT_SIZE_LOG2'(1);
               if (rd_cnt_q == C_FFT_SIZE_LOG2'(N - 1)) begin
                  state_d = UNLD_DRAIN;
               end
            end
         end
         UNLD_DRAIN: begin
            if (hs && last_beat) begin
               state_d = UNLD_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = UNLD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= UNLD_IDLE;
         rd_cnt_q  <= '0;
         rd_pipe_q <= '0;
         slice_q   <= '0;
         beat_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_cnt_q  <= rd_cnt_d;
         rd_pipe_q <= rd_pipe_d;
         slice_q   <= slice_d;
         beat_q    <= beat_d;
         done_q    <= done_d;
      end
   end

   axis_word_fifo #(
      .WIDTH (VLW_WDT),
      .DEPTH (FD)
   ) u_word_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (rd_pipe_q[MEM_RD_LAT-1]),
      .push_dat_i (mem_rd_data_i),
      .pop_i      (fifo_pop),
      .pop_dat_o  (fifo_dat),
      .count_o    (fifo_count),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // Credit accounting keeps the FIFO from ever filling past FD, so full is informational only.
   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_axis_m_fft_unload_ctrl.sv
// Bench for the FFT unload controller: frame-level model of the expected stream plus directed scenarios.
module tb_axis_m_fft_unload_ctrl;

   localparam int N  = 4096;
   localparam int M  = 8192;
   localparam int FD = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, tready, sel;
   logic start0, start1;
   assign start0 = start & ~sel;
   assign start1 = start & sel;

   logic        busy0, done0, rd_en0, tvalid0, tlast0;
   logic [11:0] addr0;
   logic [63:0] rdat0;
   logic [31:0] tdata0;
   logic        busy1, done1, rd_en1, tvalid1, tlast1;
   logic [11:0] addr1;
   logic [63:0] rdat1;
   logic [31:0] tdata1;

   axis_m_fft_unload_ctrl u_dut0 (
      .clk(clk), .rst_n(rst_n), .start_i(start0), .busy_o(busy0), .done_o(done0),
      .mem_rd_en_o(rd_en0), .mem_rd_addr_o(addr0), .mem_rd_data_i(rdat0),
      .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready),
      .m_axis_tlast(tlast0)
   );

   axis_m_fft_unload_ctrl #(.OUTPUT_MEM_OFFSET(4090)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
      .mem_rd_en_o(rd_en1), .mem_rd_addr_o(addr1), .mem_rd_data_i(rdat1),
      .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready),
      .m_axis_tlast(tlast1)
   );

   // Memory contents: re = A500_0000 | addr, im = 5A00_0000 | addr.
   function automatic logic [63:0] mem_word(input logic [11:0] a);
      return {32'hA500_0000 | {20'h0, a}, 32'h5A00_0000 | {20'h0, a}};
   endfunction

   always @(posedge clk) begin
      if (rd_en0) rdat0 <= mem_word(addr0);
      if (rd_en1) rdat1 <= mem_word(addr1);
   end

   logic        c_busy, c_done, c_rd_en, c_tvalid, c_tlast;
   logic [11:0] c_addr;
   logic [31:0] c_tdata;
   logic        c_start;
   int          off;
   assign c_busy   = sel ? busy1   : busy0;
   assign c_done   = sel ? done1   : done0;
   assign c_rd_en  = sel ? rd_en1  : rd_en0;
   assign c_tvalid = sel ? tvalid1 : tvalid0;
   assign c_tlast  = sel ? tlast1  : tlast0;
   assign c_addr   = sel ? addr1   : addr0;
   assign c_tdata  = sel ? tdata1  : tdata0;
   assign c_start  = sel ? start1  : start0;
   assign off      = sel ? 4090 : 0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Beat i of a frame: word (off + i/2) mod N, even beats carry the upper half.
   function automatic logic [31:0] exp_beat(input int i, input int o);
      int w;
      logic [31:0] base;
      w    = (o + i / 2) % N;
      base = (i % 2 == 0) ? 32'hA500_0000 : 32'h5A00_0000;
      return base | 32'(w);
   endfunction

   bit          m_busy = 0, m_done = 0, prev_stall = 0, was_busy;
   int          idx = 0, rd_issued = 0, n_done = 0;
   logic [31:0] prev_dat = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_tvalid", c_tvalid, 0);
         chk("rst_busy", c_busy, 0);
         chk("rst_rd_en", c_rd_en, 0);
         chk("rst_done", c_done, 0);
         chk("rst_tlast", c_tlast, 0);
         chk("rst_tdata", c_tdata, 0);
         m_busy = 0; m_done = 0; prev_stall = 0; idx = 0; rd_issued = 0;
      end else begin
         chk("busy", c_busy, m_busy);
         chk("done", c_done, m_done);
         if (c_done) n_done++;
         if (c_rd_en) begin
            chk("rd_only_busy", m_busy, 1);
            chk("rd_addr", c_addr, (off + rd_issued) % N);
            chk("rd_in_frame", rd_issued < N, 1);
            chk("rd_credit", (rd_issued - idx / 2) < FD, 1);
            rd_issued++;
         end
         if (c_tvalid) begin
            chk("tdata", c_tdata, exp_beat(idx, off));
            chk("tlast", c_tlast, idx == M - 1);
         end else begin
            chk("tlast_idle", c_tlast, 0);
         end
         if (prev_stall) begin
            chk("stall_tvalid", c_tvalid, 1);
            chk("stall_tdata", c_tdata, prev_dat);
         end
         prev_stall = c_tvalid && !tready;
         prev_dat   = c_tdata;
         was_busy   = m_busy;
         m_done     = 0;
         if (c_tvalid && tready) begin
            if (idx == M - 1) begin
               m_busy = 0;
               m_done = 1;
            end
            idx++;
         end
         if (c_start && !was_busy) begin
            m_busy = 1; idx = 0; rd_issued = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] last_dat;

   task automatic wait_done(input string nm, input int bound, input bit rnd);
      bit got;
      got = 0;
      for (int i = 0; i < bound; i++) begin
         @(posedge clk);
         #1;
         if (rnd) tready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (c_tvalid && c_tlast && tready) last_dat = c_tdata;
         if (c_done) begin
            got = 1;
            break;
         end
      end
      chk({nm, "_done_seen"}, got, 1);
   endtask

   initial begin
      int last_cyc, done_cyc, nrd, snap;
      rst_n = 0; start = 0; tready = 0; sel = 0;
      repeat (3) tick();
      tick();
      rst_n = 1;
      tick();

      // 1) full frame at tready = 1
      tready = 1; start = 1;
      @(negedge clk); chk("t1_c0_rd_en", c_rd_en, 0);
      tick(); start = 0;
      @(negedge clk);
      chk("t1_c1_rd_en", c_rd_en, 1);
      chk("t1_c1_addr", c_addr, 0);
      chk("t1_c1_busy", c_busy, 1);
      @(negedge clk); chk("t1_c2_tvalid", c_tvalid, 0);
      @(negedge clk);
      chk("t1_c3_tvalid", c_tvalid, 1);
      chk("t1_c3_tdata", c_tdata, 32'hA500_0000);
      @(negedge clk); chk("t1_c4_tdata", c_tdata, 32'h5A00_0000);
      last_cyc = -1; done_cyc = -1;
      for (int cyc = 5; cyc < 9000 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         if (c_tvalid && c_tlast && tready) last_cyc = cyc;
         if (c_done) done_cyc = cyc;
      end
      chk("t1_tlast_cycle", last_cyc, 8194);
      chk("t1_done_cycle", done_cyc, 8195);
      chk("t1_beats", idx, M);
      tick();

      // 2) random backpressure
      snap = n_done;
      start = 1; tick(); start = 0;
      wait_done("t2", 40000, 1);
      chk("t2_beats", idx, M);
      tick();
      chk("t2_single_done", n_done - snap, 1);
      tready = 1;
      tick();

      // 3) tready held low for 100 cycles
      tready = 0; start = 1; tick(); start = 0;
      nrd = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (c_rd_en) nrd++;
         tick();
      end
      @(negedge clk);
      chk("t3_reads_stalled", nrd, 8);
      chk("t3_tvalid_held", c_tvalid, 1);
      chk("t3_head_beat", c_tdata, 32'hA500_0000);
      tick();
      tready = 1;
      wait_done("t3", 10000, 0);
      chk("t3_beats", idx, M);
      tick();

      // 4) extra start mid-frame is ignored
      start = 1; tick(); start = 0;
      for (int i = 0; i < 3000 && idx < 1000; i++) tick();
      snap = n_done;
      start = 1; tick(); start = 0;
      wait_done("t4", 10000, 0);
      repeat (5) tick();
      @(negedge clk);
      chk("t4_single_done", n_done - snap, 1);
      chk("t4_idle_after", c_busy, 0);
      tick();

      // 5) asynchronous reset mid-frame, then a clean frame
      start = 1; tick(); start = 0;
      for (int i = 0; i < 5000 && idx < 3000; i++) tick();
      #1 rst_n = 0;
      #1;
      chk("t5_async_tvalid", c_tvalid, 0);
      chk("t5_async_busy", c_busy, 0);
      chk("t5_async_rd_en", c_rd_en, 0);
      chk("t5_async_tlast", c_tlast, 0);
      repeat (3) tick();
      rst_n = 1;
      tick();
      start = 1; tick(); start = 0;
      wait_done("t5", 10000, 0);
      chk("t5_beats", idx, M);
      chk("t5_last_beat", last_dat, 32'h5A00_0FFF);
      tick();

      // 6) non-zero memory offset
      sel = 1;
      tick();
      start = 1;
      @(negedge clk);
      tick(); start = 0;
      @(negedge clk);
      chk("t6_first_addr", c_addr, 4090);
      chk("t6_first_rd_en", c_rd_en, 1);
      @(negedge clk);
      @(negedge clk);
      chk("t6_first_beat", c_tdata, 32'hA500_0FFA);
      wait_done("t6", 10000, 0);
      chk("t6_last_beat", last_dat, 32'h5A00_0FF9);
      chk("t6_beats", idx, M);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
